open_risc_v_lsu: RTL

Load/store unit for the open_risc_v core. It sits between the execute stage and the SoC data RAM, and it is the last block needed to close out the LOAD/STORE instruction group. It accepts one memory request at a time from execute and drives a synchronous single-port data RAM with byte enables. For loads, it aligns and sign- or zero-extends the returned data and hands it to the register-file write-back as a one-cycle write pulse.

---
 rtl/open_risc_v_lsu_pkg.sv | 49 ++++
 rtl/open_risc_v_lsu_align.sv | 30 +++
 rtl/open_risc_v_lsu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/open_risc_v_lsu_pkg.sv
// Shared definitions for the open_risc_v load/store unit (package open_risc_v_defs):
// funct3 codes, FSM state encodings, access-size decode and the default RAM depth.
package open_risc_v_defs;

  localparam int RAM_AW_DEFAULT = 12;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Unsupported funct3 codes fall back to a full-word access.
  function automatic lsu_size_e access_size(input logic [2:0] funct3, input logic is_store);
    lsu_size_e size;
    size = SZ_W;
    if (is_store) begin
      case (funct3)
        SB:      size = SZ_B;
        SH:      size = SZ_H;
        SW:      size = SZ_W;
        default: size = SZ_W;
      endcase
    end else begin
      case (funct3)
        LB, LBU: size = SZ_B;
        LH, LHU: size = SZ_H;
        default: size = SZ_W;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/open_risc_v_lsu_align.sv
// Load-data aligner: picks the addressed byte/halfword out of the RAM word and
// sign- or zero-extends it according to funct3.
module open_risc_v_lsu_align
  import open_risc_v_defs::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LBU:     o_data = {24'd0, w_byte};
      LHU:     o_data = {16'd0, w_half};
      LW:      o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/open_risc_v_lsu.sv
// open_risc_v load/store unit: one request at a time into a synchronous byte-enabled RAM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses with a misalign_err pulse.
module open_risc_v_lsu
  import open_risc_v_defs::*;
#(
  parameter int RAM_AW = RAM_AW_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_store,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [4:0]        i_req_rd,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [31:0]       o_wb_data,
  output logic              o_misalign_err
);

  lsu_state_e        r_state;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [4:0]        r_rd;
  logic              r_ram_en;
  logic [3:0]        r_ram_we;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [31:0]       r_wb_data;
  logic              r_misalign;

  lsu_size_e         w_size;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic              w_accept;
  logic              w_trap;
  logic [31:0]       w_load_data;
  logic              w_unused;

  assign w_size   = access_size(i_req_funct3, i_req_store);
  assign w_accept = i_req_valid && (r_state == ST_IDLE);
  assign w_unused = ^i_req_addr[31:RAM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = ((w_size == SZ_H) && i_req_addr[0]) ||
                  ((w_size == SZ_W) && (i_req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Narrow stores replicate their data so the enabled lanes see the right bytes.
  always_comb begin
    w_we    = 4'b1111;
    w_wdata = i_req_wdata;
    case (w_size)
      SZ_B: begin
        w_we    = 4'b0001 << i_req_addr[1:0];
        w_wdata = {4{i_req_wdata[7:0]}};
      end
      SZ_H: begin
        w_we    = 4'b0011 << {i_req_addr[1], 1'b0};
        w_wdata = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!i_req_store) begin
      w_we = 4'b0000;
    end
  end

  open_risc_v_lsu_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_word    (i_ram_rdata),
    .o_data    (w_load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_store     <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_rd        <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 4'b0000;
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_trap) begin
            r_misalign <= 1'b1;
          end else if (w_accept) begin
            r_store     <= i_req_store;
            r_funct3    <= i_req_funct3;
            r_addr_lo   <= i_req_addr[1:0];
            r_rd        <= i_req_rd;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_we;
            r_ram_addr  <= i_req_addr[RAM_AW+1:2];
            r_ram_wdata <= w_wdata;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: r_state <= r_store ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          r_wb_valid <= (r_rd != 5'd0);
          r_wb_rd    <= r_rd;
          r_wb_data  <= w_load_data;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready    = (r_state == ST_IDLE);
  assign o_ram_en       = r_ram_en;
  assign o_ram_we       = r_ram_we;
  assign o_ram_addr     = r_ram_addr;
  assign o_ram_wdata    = r_ram_wdata;
  assign o_wb_valid     = r_wb_valid;
  assign o_wb_rd        = r_wb_rd;
  assign o_wb_data      = r_wb_data;
  assign o_misalign_err = r_misalign;

endmodule
